serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Multi-cycle, bit-serial two's-complement adder; the additive counterpart to the team's combinational 8-bit subtractor.
- Operands are latched on a start handshake and summed LSB-first at one bit per clock. The block then reports sum, carry-out and signed overflow with a one-cycle done pulse.
- Sits beside the subtractor in the lab ALU datapath. Used where area matters more than latency, and as the reference for the sequential-datapath lab.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32).
- CNT_W, 6, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- X  input  WIDTH  augend, captured when start is accepted.
- Y  input  WIDTH  addend, captured when start is accepted.
- cin  input  1  carry-in, captured when start is accepted.
- busy  output  1  high while in ADD.
- done  output  1  one-cycle pulse; result, cout and overflow are valid.
- result  output  WIDTH  registered sum X+Y+cin, modulo 2^WIDTH.
- cout  output  1  unsigned carry-out of bit WIDTH-1.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset:
  - rst_n low forces state IDLE immediately, without waiting for a clock edge.
  - busy=0, done=0, result=0, cout=0, overflow=0.
  - Internal operand shift registers, sum shift register, carry flop and bit counter all clear to 0.
- States: IDLE, ADD, DONE.
- IDLE:
  - start=1 at edge E0 latches X into A_sr, Y into B_sr, cin into carry, and clears the counter. Next state is ADD and busy=1.
  - start=0 keeps the block in IDLE.
- ADD, one bit per edge:
  - s = A_sr[0]^B_sr[0]^carry.
  - carry <= majority(A_sr[0], B_sr[0], carry).
  - A_sr and B_sr shift right; s shifts into the MSB of S_sr. The counter increments.
  - Before the final bit (counter==WIDTH-1), save carry as c_msb_in.
  - On the edge that processes bit WIDTH-1 (edge E_WIDTH):
    - result <= final S_sr.
    - cout <= final carry.
    - overflow <= c_msb_in ^ final carry.
    - next state is DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then unconditionally IDLE.
- Latency:
  - start is sampled at E0; the outputs update at E_WIDTH and done is high from E_WIDTH to E_WIDTH+1.
  - Minimum start-to-start spacing is WIDTH+2 cycles.
- Output stability: result, cout and overflow hold their last values until the next completion. They do not change during ADD, and X, Y and cin may change freely after acceptance.
- start while busy or in DONE: ignored, with no queueing. start held high continuously re-triggers on the first IDLE cycle after DONE.
- Arithmetic: result = (X+Y+cin) mod 2^WIDTH. cout is bit WIDTH of the full sum. overflow follows two's-complement rules.
- Reset during ADD: aborts with no done pulse; outputs return to their reset values.
- X/Y/cin values that are X or Z while IDLE with start=0 must not propagate into any register.

Test Plan:
- Basic add: reset, then start with X=8'h05, Y=8'h03, cin=0 -> busy high for 8 cycles; done pulses exactly 8 edges after the start edge; result=8'h08, cout=0, overflow=0.
- Unsigned wrap, then signed overflow:
  - X=8'hFF, Y=8'h01 -> result=8'h00, cout=1, overflow=0.
  - Next, X=8'h7F, Y=8'h01 -> result=8'h80, cout=0, overflow=1.
- Both flags set, and carry-in:
  - X=8'h80, Y=8'h80 -> result=8'h00, cout=1, overflow=1.
  - X=8'hFF, Y=8'h00, cin=1 -> result=8'h00, cout=1, overflow=0.
- Busy handling: start a 8'h10+8'h20 add; pulse start with X=8'hAA during cycle 3 of ADD and again during DONE -> single done, result=8'h30. Only one start is accepted; the next start in IDLE works normally.
- Reset mid-op: start 8'h40+8'h40; drop rst_n asynchronously after 4 ADD cycles -> immediate busy=0, result=0, no done. After release, 8'h01+8'h01 gives 8'h02.
- Continuous start held high with a random set of 200 operand pairs -> one completion every 10 cycles; each result, cout and overflow matches the golden model X+Y+cin.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle, bit-serial two's-complement adder.
//
// Operands are captured on an accepted start request. They are then summed
// LSB-first, one bit per clock, over WIDTH cycles. At completion the
// registered sum, carry-out and signed overflow update together, and done
// pulses for one cycle.
//
// Parameters:
//   WIDTH  operand/result width in bits (2..32)
//   CNT_W  bit-counter width, 2**CNT_W must exceed WIDTH
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request, sampled only while idle
//   X, Y      augend / addend, captured when start is accepted
//   cin       carry-in, captured when start is accepted
//   busy      high while bits are being summed
//   done      one-cycle pulse, result/cout/overflow valid
//   result    registered sum X+Y+cin modulo 2**WIDTH
//   cout      unsigned carry-out of the MSB
//   overflow  signed overflow (carry into MSB xor carry out of MSB)
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  if ((2 ** CNT_W) <= WIDTH) begin : g_bad_cnt_w
    $error("serial_adder: CNT_W too small for WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             bit_s;
  logic             bit_c;
  logic             last_bit;
  logic             c_msb_in;
  logic             accept;

  // Full-adder cell for the current bit position.
  always_comb begin
    bit_s    = a_sr[0] ^ b_sr[0] ^ carry;
    bit_c    = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    last_bit = (cnt == LAST_BIT);
    // While the MSB is being processed, the carry flop holds the carry into
    // the MSB, which is what the signed-overflow rule needs.
    c_msb_in = carry;
    // Only a clean 1 on start is honoured; an unknown start is not accepted.
    accept   = (state == IDLE) && (start == 1'b1);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ADD;
      ADD:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    busy = (state == ADD);
    done = (state == DONE);
  end

  // Serial datapath. Operand registers load only on an accepted start, so
  // unknown operand values on idle cycles never reach the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      s_sr     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_sr  <= X;
      b_sr  <= Y;
      s_sr  <= '0;
      carry <= cin;
      cnt   <= '0;
    end else if (state == ADD) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      s_sr  <= {bit_s, s_sr[WIDTH-1:1]};
      carry <= bit_c;
      cnt   <= cnt + 1'b1;
      // The final bit completes the sum; publish all results on this edge.
      if (last_bit) begin
        result   <= {bit_s, s_sr[WIDTH-1:1]};
        cout     <= bit_c;
        overflow <= c_msb_in ^ bit_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder (WIDTH = 8).
// Expected results come from an integer-arithmetic model and are queued when
// an operation is driven. A monitor pops and compares them on every done pulse.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  int n_assert = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_exp    = 0;

  // Scoreboard entry: {cout, overflow, result}.
  logic [W+1:0] sb[$];
  logic [W+1:0] mon_e;
  logic         prev_done = 1'b0;

  serial_adder #(.WIDTH(W), .CNT_W(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .X        (X),
    .Y        (Y),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    logic [W:0] s;
    logic       ov;
    s  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    ov = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    return {s[W], ov, s[W-1:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Completion monitor.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_done++;
      check("done_single_cycle", {31'd0, prev_done}, 32'd0);
      check("done_has_expected", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("result",   {24'd0, result},   {24'd0, mon_e[W-1:0]});
        check("cout",     {31'd0, cout},     {31'd0, mon_e[W+1]});
        check("overflow", {31'd0, overflow}, {31'd0, mon_e[W]});
      end
    end
    prev_done = done;
  end

  // Start one operation and follow it to completion, checking timing.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int k;
    int nbusy;
    @(posedge clk); #1;
    X = x; Y = y; cin = c; start = 1'b1;
    sb.push_back(model(x, y, c));
    n_exp++;
    @(posedge clk); #1;
    start = 1'b0;
    X = 'x; Y = 'x; cin = 1'bx;
    k = 0;
    nbusy = 0;
    while (k < 30) begin
      @(negedge clk);
      k++;
      if (done === 1'b1) break;
      if (busy === 1'b1) nbusy++;
    end
    check("latency_negedges", k, 32'd9);
    check("busy_cycles", nbusy, 32'd8);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    rst_n = 1'b1;
    start = 1'b0;
    X = 'x; Y = 'x; cin = 1'bx;
    #1 rst_n = 1'b0;
    #3;
    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_done",     {31'd0, done},     32'd0);
    check("rst_result",   {24'd0, result},   32'd0);
    check("rst_cout",     {31'd0, cout},     32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    // Idle with unknown operands and start low: nothing may move.
    repeat (4) @(negedge clk);
    check("idle_busy",   {31'd0, busy}, 32'd0);
    check("idle_result", {24'd0, result}, 32'd0);

    // Basic add, wrap, overflow, both flags, carry-in.
    run_op(8'h05, 8'h03, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0);
    run_op(8'h80, 8'h80, 1'b0);
    run_op(8'hFF, 8'h00, 1'b1);

    // Busy handling: start pulses during ADD and during DONE are ignored.
    @(posedge clk); #1;
    X = 8'h10; Y = 8'h20; cin = 1'b0; start = 1'b1;
    sb.push_back(model(8'h10, 8'h20, 1'b0));
    n_exp++;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    X = 8'hAA; Y = 8'hAA; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (k < 30) begin
      @(negedge clk);
      k++;
      if (done === 1'b1) break;
    end
    check("busy_test_done_seen", {31'd0, done}, 32'd1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_in_done_ignored", {31'd0, busy}, 32'd0);
    repeat (12) @(negedge clk);
    check("busy_test_done_count", n_done, n_exp);
    check("busy_test_result", {24'd0, result}, 32'h30);
    run_op(8'h33, 8'h11, 1'b0);

    // Reset in the middle of an operation.
    @(posedge clk); #1;
    X = 8'h40; Y = 8'h40; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy",     {31'd0, busy},     32'd0);
    check("midrst_done",     {31'd0, done},     32'd0);
    check("midrst_result",   {24'd0, result},   32'd0);
    check("midrst_cout",     {31'd0, cout},     32'd0);
    check("midrst_overflow", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_no_done", n_done, n_exp);
    run_op(8'h01, 8'h01, 1'b0);

    // Start held high: back-to-back operations every W+2 cycles.
    @(posedge clk); #1;
    for (int i = 0; i < 200; i++) begin
      X = W'($urandom);
      Y = W'($urandom);
      cin = 1'($urandom);
      start = 1'b1;
      sb.push_back(model(X, Y, cin));
      n_exp++;
      @(posedge clk); #1;
      check("cont_accepted", {31'd0, busy}, 32'd1);
      repeat (9) @(posedge clk);
      #1;
    end
    start = 1'b0;
    repeat (5) @(negedge clk);

    check("final_done_count", n_done, n_exp);
    check("final_sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
